// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store sequencer with ack timeout; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0] funct3_q, funct3_d;
  logic we_q, we_d;
  logic [7:0] cnt_q, cnt_d;
  logic illegal, misalign, acc;
  logic [1:0] size;
  logic [4:0] sh;
  logic [3:0] be;
  logic [31:0] lane, ld_val, wd_rep;
  always_comb begin
    illegal = start_wr ? (funct3[2] | (funct3[1:0] == 2'b11)) : ((funct3 == 3'd3) | (funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
`else
    misalign = 1'b0;
`endif
    size = funct3_q[1:0];
    acc = state_q == ACCESS;
    be = size == 2'd0 ? 4'b0001 << addr_q[1:0] : size == 2'd1 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    sh = size == 2'd0 ? {addr_q[1:0], 3'b000} : size == 2'd1 ? {addr_q[1], 4'b0000} : 5'd0;
    lane = mem_rdata >> sh;
    ld_val = size == 2'd0 ? {{24{~funct3_q[2] & lane[7]}}, lane[7:0]} :
             size == 2'd1 ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} : lane;
    wd_rep = size == 2'd0 ? {4{wdata_q[7:0]}} : size == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    mem_req = acc;
    mem_we = acc & we_q;
    mem_addr = acc ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be = acc ? be : 4'b0000;
    mem_wdata = acc ? wd_rep : 32'd0;
    rdata = rdata_q;
    done = state_q == DONE;
    err = state_q == ERROR;
    busy = state_q != IDLE;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    funct3_d = funct3_q;
    we_d = we_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start_wr | start_rd) begin
        addr_d = addr;
        wdata_d = wdata;
        funct3_d = funct3;
        we_d = start_wr;
        cnt_d = 8'd0;
        state_d = (illegal | misalign) ? ERROR : ACCESS;
      end
      ACCESS: if (mem_ack) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : ld_val;
      end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = 8'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      funct3_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      funct3_q <= funct3_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, which sets the maximum number of ACCESS cycles to wait for mem_ack (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start_rd, input, 1 bit: load request from the main controller.
REQ-005 SHALL have port start_wr, input, 1 bit: store request from the main controller.
REQ-006 SHALL have port funct3, input, 3 bits: access size and signedness code.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: store data, with the valid bits right-aligned.
REQ-009 SHALL have port mem_req / mem_we, output, 1 bit each: memory request and write strobe.
REQ-010 SHALL have port mem_addr, output, 32 bits: word address, with bits [1:0] always 0.
REQ-011 SHALL have port mem_be, output, 4 bits: byte-lane enables.
REQ-012 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-013 SHALL have port mem_rdata, input, 32 bits: memory read word.
REQ-014 SHALL have port mem_ack, input, 1 bit: memory completion.
REQ-015 SHALL have port rdata, output, 32 bits: extended load result.
REQ-016 SHALL have port done / err / busy, output, 1 bit each: completion pulse, error pulse, and busy level.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCESS, DONE and ERROR, and busy=1 in every state other than IDLE.
REQ-018 IDLE: SHALL capture the request when start_wr or start_rd is 1; start_wr SHALL win if both are 1; a legal request SHALL go to ACCESS and an illegal one to ERROR.
REQ-019 SHALL treat these funct3 codes as illegal: loads 3, 6 and 7; stores 3 through 7.
REQ-020 SHALL ignore start_rd and start_wr in every state other than IDLE, and SHALL hold the captured addr, funct3 and wdata stable until the FSM returns to IDLE.
REQ-021 ACCESS: SHALL assert mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata held constant for the whole state.
REQ-022 ACCESS: mem_ack=1 SHALL end the access and go to DONE; on a load, rdata SHALL be registered on that same edge.
REQ-023 ACCESS: SHALL count ACCESS cycles; reaching TIMEOUT_CYCLES without mem_ack SHALL go to ERROR.
REQ-024 DONE and ERROR: each state SHALL last exactly 1 cycle and then return to IDLE; done=1 in DONE, err=1 in ERROR, and mem_req=0 in both.
REQ-025 Minimum latency: start in cycle N, mem_req in N+1, and done in N+2 when mem_ack arrives in N+1.
REQ-026 Byte enables: byte accesses (funct3 0 and 4) SHALL use mem_be = 0001 shifted left by addr[1:0]; halfword accesses (funct3 1 and 5) SHALL use 0011 shifted left by 2*addr[1]; word accesses SHALL use 1111.
REQ-027 Store data: a byte store SHALL replicate wdata[7:0] to all 4 lanes; a halfword store SHALL replicate wdata[15:0] to both halves; a word store SHALL pass wdata through unchanged.
REQ-028 Load data: SHALL select the addressed lane of mem_rdata and sign-extend it for funct3 0 and 1, or zero-extend it for funct3 4 and 5.
REQ-029 SHALL hold rdata until the next completed load, and SHALL leave it unchanged on stores and errors.
REQ-030 SHALL ignore a mem_ack that arrives outside ACCESS.

Reset
REQ-031 rst=1 on a clock edge SHALL force IDLE from any state, including mid-ACCESS, and SHALL abandon any pending access without an err or done pulse.
REQ-032 Reset values: mem_req, mem_we, done, err and busy = 0; mem_be = 0000; mem_addr, mem_wdata and rdata = 0; timeout counter = 0.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]≠0 SHALL go IDLE→ERROR with no mem_req.
REQ-034 Without LSU_MISALIGN_TRAP_EN, SHALL ignore the misaligned low address bits (halfword: addr[0]; word: addr[1:0]) for lane selection, and SHALL complete the access normally.

Verification
REQ-035 LB with addr=0x103 and mem_rdata=0x80FF_FF00 (ack in the first ACCESS cycle) -> mem_addr=0x100, mem_be=1000, rdata=0xFFFF_FF80, and done at N+2.
REQ-036 SH with addr=0x202 and wdata=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD; rdata unchanged.
REQ-037 LHU with addr=0x0, mem_ack delayed 3 cycles, and mem_rdata=0x0000_8001 -> mem_req high for 4 cycles, then rdata=0x0000_8001 and a single done pulse.
REQ-038 LW with mem_ack never asserted and TIMEOUT_CYCLES=15 -> mem_req high for exactly 15 cycles, then err=1 for 1 cycle, with no done.
REQ-039 LW with addr=0x6 -> with the macro: err and no mem_req; without it: mem_addr=0x4, mem_be=1111, done.
REQ-040 rst asserted during ACCESS, plus start_rd and start_wr asserted together -> after rst, all outputs are at reset values; a simultaneous start executes the store.
